// File: rtl/eth_rx_if.sv
// Byte-wide wire receive inputs plus CPU-side payload and end-of-frame status of eth_rx.
interface eth_rx_if;
    logic        in_rxen;
    logic [7:0]  in_rxd;
    logic        out_rx_valid;
    logic [7:0]  out_rx_data;
    logic        out_rx_sof;
    logic        out_rx_done;
    logic [10:0] out_rx_len;
    logic        out_rx_crc_ok;
    logic        out_rx_err;

    modport master (
        output in_rxen, in_rxd,
        input  out_rx_valid, out_rx_data, out_rx_sof, out_rx_done,
        input  out_rx_len, out_rx_crc_ok, out_rx_err
    );
    modport slave (
        input  in_rxen, in_rxd,
        output out_rx_valid, out_rx_data, out_rx_sof, out_rx_done,
        output out_rx_len, out_rx_crc_ok, out_rx_err
    );
endinterface

// File: rtl/eth_rx.sv
// Ethernet receive controller: preamble/SFD lock, payload forwarding with the FCS
// withheld by a 4-byte delay line, CRC-32 residue check and end-of-frame status.
module eth_rx #(
    parameter int PREAMBLE_MIN = 7,
    parameter int MIN_FRAME    = 64,
    parameter int MAX_FRAME    = 1518
) (
    input logic     clock,
    input logic     reset_n,
    eth_rx_if.slave rx
);
    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    localparam logic [3:0]  PRE_MIN = 4'(PREAMBLE_MIN);
    localparam logic [10:0] MIN_B   = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_B   = 11'(MAX_FRAME);
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    state_t          state, state_nxt;
    logic [3:0]      pre_cnt;
    logic [10:0]     byte_cnt;
    logic [31:0]     crc;
    logic [3:0][7:0] dly;
    logic            ovf;
    logic            emit, end_data, end_ovf, crc_ok_nxt;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:
                if (rx.in_rxen) state_nxt = (rx.in_rxd == 8'h55) ? PREAMBLE : DROP;
            PREAMBLE:
                if (!rx.in_rxen)                                 state_nxt = IDLE;
                else if (rx.in_rxd == 8'h55)                     state_nxt = PREAMBLE;
                else if (rx.in_rxd == 8'hD5 && pre_cnt >= PRE_MIN) state_nxt = DATA;
                else                                             state_nxt = DROP;
            DATA:
                if (!rx.in_rxen)            state_nxt = IDLE;
                else if (byte_cnt == MAX_B) state_nxt = DROP;
            DROP:
                if (!rx.in_rxen) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A beat leaves the delay line only once it holds 4 bytes; the byte that
    // would push the count past MAX_FRAME is never forwarded.
    always_comb begin
        emit       = (state == DATA) && rx.in_rxen && (byte_cnt >= 11'd4) && (byte_cnt < MAX_B);
        end_data   = (state == DATA) && !rx.in_rxen;
        end_ovf    = (state == DROP) && !rx.in_rxen && ovf;
        crc_ok_nxt = (crc == RESIDUE) && (byte_cnt >= 11'd4);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt          <= '0;
            byte_cnt         <= '0;
            crc              <= 32'hFFFFFFFF;
            dly              <= '0;
            ovf              <= 1'b0;
            rx.out_rx_valid  <= 1'b0;
            rx.out_rx_data   <= '0;
            rx.out_rx_sof    <= 1'b0;
            rx.out_rx_done   <= 1'b0;
            rx.out_rx_len    <= '0;
            rx.out_rx_crc_ok <= 1'b0;
            rx.out_rx_err    <= 1'b0;
        end else begin
            if (state == IDLE && state_nxt == PREAMBLE)
                pre_cnt <= 4'd1;
            else if (state == PREAMBLE && state_nxt == PREAMBLE && pre_cnt != 4'hF)
                pre_cnt <= pre_cnt + 4'd1;

            if (state == PREAMBLE && state_nxt == DATA) begin
                crc      <= 32'hFFFFFFFF;
                byte_cnt <= '0;
            end else if (state == DATA && rx.in_rxen) begin
                crc      <= crc_byte(crc, rx.in_rxd);
                byte_cnt <= byte_cnt + 11'd1;
                dly      <= {dly[2:0], rx.in_rxd};
            end

            if (state == DATA && state_nxt == DROP) ovf <= 1'b1;
            else if (state_nxt == IDLE)             ovf <= 1'b0;

            rx.out_rx_valid <= emit;
            rx.out_rx_sof   <= emit && (byte_cnt == 11'd4);
            if (emit) rx.out_rx_data <= dly[3];

            rx.out_rx_done <= end_data || end_ovf;
            if (end_data) begin
                rx.out_rx_len    <= (byte_cnt < 11'd4) ? 11'd0 : byte_cnt - 11'd4;
                rx.out_rx_crc_ok <= crc_ok_nxt;
                rx.out_rx_err    <= !crc_ok_nxt || (byte_cnt < MIN_B);
            end else if (end_ovf) begin
                rx.out_rx_len    <= MAX_B - 11'd4;
                rx.out_rx_crc_ok <= 1'b0;
                rx.out_rx_err    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_eth_rx.sv
// Randomized frame-level bench for eth_rx: payload, SOF, latency and status are
// predicted from frame contents by a reference model built on queues.
module tb_eth_rx;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    eth_rx_if rx();

    eth_rx dut (.clock(clock), .reset_n(reset_n), .rx(rx));

    always #5 clock = ~clock;

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {int len; bit ok; bit err; int cyc;} done_t;

    byte unsigned got_q[$];
    int           sof_q[$];
    done_t        done_q[$];
    int           first_cyc;

    always @(negedge clock) begin
        done_t d;
        if (rx.out_rx_valid === 1'b1) begin
            if (got_q.size() == 0) first_cyc = cyc;
            if (rx.out_rx_sof === 1'b1) sof_q.push_back(got_q.size());
            got_q.push_back(rx.out_rx_data);
        end
        if (rx.out_rx_done === 1'b1) begin
            d.len = int'(rx.out_rx_len); d.ok = rx.out_rx_crc_ok; d.err = rx.out_rx_err; d.cyc = cyc;
            done_q.push_back(d);
        end
    end

    // Reference model state
    byte unsigned frm[$];
    byte unsigned exp_q[$];
    bit  exp_done, exp_ok, exp_err;
    int  exp_len, fall_cyc, b4_cyc;

    function automatic logic [31:0] fcs_of(input byte unsigned p[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (p[i]) begin
            c ^= {24'h0, p[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Post-SFD bytes: npay payload bytes then 4 FCS bytes, low byte first.
    task automatic build(input int npay, input bit seq, input bit corrupt);
        logic [31:0] f;
        frm.delete();
        for (int i = 0; i < npay; i++) frm.push_back(seq ? 8'(i) : 8'($urandom));
        f = fcs_of(frm);
        for (int k = 0; k < 4; k++) frm.push_back(8'(f >> (8 * k)) ^ ((k == 0 && corrupt) ? 8'h01 : 8'h00));
    endtask

    task automatic model(input int npre, input bit sfd_ok);
        int n = frm.size();
        byte unsigned pay[$];
        exp_q.delete();
        exp_done = 0; exp_len = 0; exp_ok = 0; exp_err = 0;
        if (npre < 7 || !sfd_ok) return;
        exp_done = 1;
        if (n > 1518) begin
            for (int i = 0; i < 1514; i++) exp_q.push_back(frm[i]);
            exp_len = 1514; exp_ok = 0; exp_err = 1;
        end else begin
            for (int i = 0; i < n - 4; i++) pay.push_back(frm[i]);
            exp_q   = pay;
            exp_len = (n >= 4) ? n - 4 : 0;
            exp_ok  = (n >= 4) && (fcs_of(pay) == {frm[n-1], frm[n-2], frm[n-3], frm[n-4]});
            exp_err = !exp_ok || (n < 64);
        end
    endtask

    task automatic drive(input int npre, input byte unsigned sfd, input int gap);
        for (int i = 0; i < npre; i++) begin
            @(negedge clock); rx.in_rxen = 1'b1; rx.in_rxd = 8'h55;
        end
        @(negedge clock); rx.in_rxen = 1'b1; rx.in_rxd = sfd;
        foreach (frm[i]) begin
            @(negedge clock); rx.in_rxd = frm[i];
            if (i == 4) b4_cyc = cyc + 1;
        end
        @(negedge clock); rx.in_rxen = 1'b0; rx.in_rxd = 8'h00; fall_cyc = cyc + 1;
        repeat (gap - 1) @(negedge clock);
    endtask

    task automatic clear_mon();
        got_q.delete(); sof_q.delete(); done_q.delete(); first_cyc = -1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; rx.in_rxen = 1'b0; rx.in_rxd = 8'h00;
        repeat (3) @(negedge clock);
        vectors++;
        if ({rx.out_rx_valid, rx.out_rx_data, rx.out_rx_sof, rx.out_rx_done, rx.out_rx_len,
             rx.out_rx_crc_ok, rx.out_rx_err} !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b data=%h sof=%b done=%b len=%0d ok=%b err=%b, want all 0",
                     rx.out_rx_valid, rx.out_rx_data, rx.out_rx_sof, rx.out_rx_done, rx.out_rx_len,
                     rx.out_rx_crc_ok, rx.out_rx_err);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_frame(input string nm, input int npay, input bit seq, input bit corrupt,
                              input int npre, input bit chk_lat);
        int bad = 0;
        clear_mon();
        build(npay, seq, corrupt);
        model(npre, 1'b1);
        drive(npre, 8'hD5, 1);
        repeat (3) @(negedge clock);
        vectors++;
        if (got_q.size() !== exp_q.size()) begin
            miscompares++; $display("FAIL %s beats: got %0d want %0d", nm, got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) bad++;
        vectors++;
        if (bad !== 0) begin
            miscompares++; $display("FAIL %s data: %0d bytes differ, want 0", nm, bad);
        end
        vectors++;
        if (sof_q.size() !== 1 || sof_q[0] !== 0) begin
            miscompares++; $display("FAIL %s sof: got %0d sof beats, want 1 on beat 0", nm, sof_q.size());
        end
        vectors++;
        if (done_q.size() !== 1) begin
            miscompares++; $display("FAIL %s done_count: got %0d want 1", nm, done_q.size());
        end else begin
            vectors++;
            if (done_q[0].len !== exp_len || done_q[0].ok !== exp_ok || done_q[0].err !== exp_err) begin
                miscompares++;
                $display("FAIL %s status: got len=%0d ok=%b err=%b want len=%0d ok=%b err=%b", nm,
                         done_q[0].len, done_q[0].ok, done_q[0].err, exp_len, exp_ok, exp_err);
            end
            vectors++;
            if (done_q[0].cyc !== fall_cyc) begin
                miscompares++; $display("FAIL %s done_cycle: got %0d want %0d", nm, done_q[0].cyc, fall_cyc);
            end
        end
        if (chk_lat) begin
            vectors++;
            if (first_cyc !== b4_cyc) begin
                miscompares++; $display("FAIL %s first_beat_cycle: got %0d want %0d", nm, first_cyc, b4_cyc);
            end
        end
    endtask

    task automatic test_bad_preamble();
        clear_mon();
        build(60, 1'b0, 1'b0);
        model(3, 1'b1);
        drive(3, 8'hD5, 1);
        repeat (3) @(negedge clock);
        vectors++;
        if (got_q.size() !== exp_q.size() || done_q.size() !== int'(exp_done)) begin
            miscompares++;
            $display("FAIL bad_preamble: got %0d beats %0d dones, want %0d beats %0d dones",
                     got_q.size(), done_q.size(), exp_q.size(), exp_done);
        end
        test_frame("after_bad_preamble", 46 + int'($urandom_range(0, 100)), 1'b0, 1'b0, 7, 1'b1);
    endtask

    task automatic test_oversize();
        int bad = 0;
        clear_mon();
        build(1596, 1'b0, 1'b0);
        model(7, 1'b1);
        drive(7, 8'hD5, 1);
        repeat (3) @(negedge clock);
        vectors++;
        if (got_q.size() !== 1514) begin
            miscompares++; $display("FAIL oversize_beats: got %0d want 1514", got_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) bad++;
        vectors++;
        if (bad !== 0) begin
            miscompares++; $display("FAIL oversize_data: %0d bytes differ, want 0", bad);
        end
        vectors++;
        if (done_q.size() !== 1 || done_q[0].len !== exp_len || done_q[0].ok !== exp_ok ||
            done_q[0].err !== exp_err || done_q[0].cyc !== fall_cyc) begin
            miscompares++;
            $display("FAIL oversize_status: got %0d dones, want 1 with len=%0d ok=%b err=%b at cycle %0d",
                     done_q.size(), exp_len, exp_ok, exp_err, fall_cyc);
        end
    endtask

    task automatic test_mid_reset();
        clear_mon();
        build(60, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clock); rx.in_rxen = 1'b1; rx.in_rxd = 8'h55;
        end
        @(negedge clock); rx.in_rxd = 8'hD5;
        foreach (frm[i]) begin
            @(negedge clock); #1;
            if (got_q.size() == 30) break;
            rx.in_rxd = frm[i];
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({rx.out_rx_valid, rx.out_rx_data, rx.out_rx_sof, rx.out_rx_done, rx.out_rx_len,
             rx.out_rx_crc_ok, rx.out_rx_err} !== 24'h0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got valid=%b data=%h sof=%b len=%0d, want all 0",
                     rx.out_rx_valid, rx.out_rx_data, rx.out_rx_sof, rx.out_rx_len);
        end
        rx.in_rxen = 1'b0; rx.in_rxd = 8'h00;
        @(negedge clock); reset_n = 1'b1;
        repeat (4) @(negedge clock);
        vectors++;
        if (done_q.size() !== 0 || got_q.size() !== 30) begin
            miscompares++;
            $display("FAIL mid_reset_abort: got %0d dones %0d beats, want 0 dones 30 beats",
                     done_q.size(), got_q.size());
        end
        test_frame("after_reset", 60, 1'b1, 1'b0, 7, 1'b1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            int npre = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(7, 20));
            int bad  = 0;
            clear_mon();
            build(int'($urandom_range(10, 300)), 1'b0, 1'($urandom_range(0, 1)));
            model(npre, 1'b1);
            drive(npre, 8'hD5, 1 + int'($urandom_range(0, 3)));
            repeat (3) @(negedge clock);
            foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) bad++;
            vectors++;
            if (got_q.size() !== exp_q.size() || bad !== 0) begin
                miscompares++;
                $display("FAIL random%0d payload: got %0d beats (%0d differ), want %0d beats",
                         t, got_q.size(), bad, exp_q.size());
            end
            vectors++;
            if (done_q.size() !== int'(exp_done) ||
                (exp_done && (done_q[0].len !== exp_len || done_q[0].ok !== exp_ok || done_q[0].err !== exp_err))) begin
                miscompares++;
                $display("FAIL random%0d status: got %0d dones, want %0d with len=%0d ok=%b err=%b",
                         t, done_q.size(), exp_done, exp_len, exp_ok, exp_err);
            end
        end
    endtask

    task automatic test_back_to_back();
        byte unsigned exp_all[$];
        int len_a, len_b, bad = 0;
        bit ok_a, err_a, ok_b, err_b;
        clear_mon();
        build(int'($urandom_range(46, 120)), 1'b0, 1'b0);
        model(7, 1'b1);
        exp_all = exp_q; len_a = exp_len; ok_a = exp_ok; err_a = exp_err;
        drive(7, 8'hD5, 1);
        build(int'($urandom_range(10, 40)), 1'b0, 1'b1);
        model(7, 1'b1);
        foreach (exp_q[i]) exp_all.push_back(exp_q[i]);
        len_b = exp_len; ok_b = exp_ok; err_b = exp_err;
        drive(7, 8'hD5, 1);
        repeat (3) @(negedge clock);
        foreach (exp_all[i]) if (i < got_q.size() && got_q[i] !== exp_all[i]) bad++;
        vectors++;
        if (got_q.size() !== exp_all.size() || bad !== 0 || sof_q.size() !== 2) begin
            miscompares++;
            $display("FAIL b2b_payload: got %0d beats (%0d differ) %0d sofs, want %0d beats 2 sofs",
                     got_q.size(), bad, sof_q.size(), exp_all.size());
        end
        vectors++;
        if (done_q.size() !== 2 ||
            done_q[0].len !== len_a || done_q[0].ok !== ok_a || done_q[0].err !== err_a ||
            done_q[1].len !== len_b || done_q[1].ok !== ok_b || done_q[1].err !== err_b) begin
            miscompares++;
            $display("FAIL b2b_status: got %0d dones, want 2 (len %0d/%0d ok %b/%b err %b/%b)",
                     done_q.size(), len_a, len_b, ok_a, ok_b, err_a, err_b);
        end
    endtask

    initial begin
        rx.in_rxen = 1'b0;
        rx.in_rxd  = 8'h00;
        test_reset();
        test_frame("valid", 60, 1'b1, 1'b0, 7, 1'b1);
        test_frame("bad_fcs", 60, 1'b1, 1'b1, 7, 1'b1);
        test_frame("runt", 20, 1'b1, 1'b0, 7, 1'b1);
        test_frame("long_preamble", 100, 1'b0, 1'b0, 18, 1'b1);
        test_bad_preamble();
        test_oversize();
        test_mid_reset();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/eth_rx.md
Name: eth_rx

Overview:
- Receive-side counterpart of the Ethernet transmit controller.
- Samples the byte-wide wire interface (in_rxen/in_rxd), locks onto preamble plus SFD, and strips both.
- Forwards payload bytes (destination MAC through the end of data) to the MCU/CPU, withholding the 4-byte FCS.
- At end of frame, reports CRC-32 status, length and error flags in a one-cycle status pulse.

Parameters:
- PREAMBLE_MIN, 7: minimum count of 0x55 bytes required before the SFD.
- MIN_FRAME, 64: minimum frame bytes after the SFD, FCS included.
- MAX_FRAME, 1518: maximum frame bytes after the SFD, FCS included.

Ports:
- clock  input  1  system clock, all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- in_rxen  input  1  wire receive enable; high for the whole frame.
- in_rxd  input  8  wire receive data; one byte per clock while in_rxen=1.
- out_rx_valid  output  1  out_rx_data holds a payload byte this cycle.
- out_rx_data  output  8  payload byte.
- out_rx_sof  output  1  high with the first payload byte of a frame.
- out_rx_done  output  1  one-cycle end-of-frame status strobe.
- out_rx_len  output  11  payload byte count (FCS excluded); valid with out_rx_done.
- out_rx_crc_ok  output  1  FCS matched; valid with out_rx_done.
- out_rx_err  output  1  runt, oversize or bad CRC; valid with out_rx_done.

Behaviour:
- Reset: all outputs are 0; state is IDLE; counters are 0; CRC register is 0xFFFFFFFF.
  - Asserting reset_n low mid-frame aborts the frame immediately.
  - No out_rx_done is produced for the aborted frame.
- State IDLE:
  - in_rxen=1 and in_rxd=0x55: go to PREAMBLE, pre_cnt=1.
  - in_rxen=1 with any other byte: go to DROP.
- State PREAMBLE:
  - 0x55: pre_cnt increments, saturating at 15.
  - 0xD5 with pre_cnt>=PREAMBLE_MIN: go to DATA; CRC=0xFFFFFFFF; byte_cnt=0.
  - 0xD5 with pre_cnt<PREAMBLE_MIN: go to DROP.
  - Any other byte: go to DROP.
  - in_rxen=0: go to IDLE silently.
- State DATA:
  - Each byte updates the CRC: reflected poly 0xEDB88320, LSB-first, one full byte per clock.
  - Each byte increments byte_cnt and shifts into a 4-entry delay line.
  - Once the line holds 4 bytes, each new byte pushes the oldest byte out.
  - Pushed-out byte: out_rx_valid=1, out_rx_data=that byte, registered, on the clock edge that samples the new byte.
  - Fixed latency: payload byte k appears one cycle after wire byte k+4 is sampled.
  - out_rx_sof=1 only with payload byte 0.
  - byte_cnt reaching MAX_FRAME+1: go to DROP with the oversize flag set; forwarding stops.
- End of frame (in_rxen falls while in DATA):
  - The 4 bytes left in the delay line are the FCS and are discarded.
  - Next cycle: out_rx_done=1 for exactly one cycle.
  - out_rx_len = byte_cnt-4, or 0 if byte_cnt<4.
  - out_rx_crc_ok = (CRC register == 0xDEBB20E3) and byte_cnt>=4.
  - out_rx_err = !crc_ok or byte_cnt<MIN_FRAME or oversize.
  - State returns to IDLE.
  - out_rx_len, out_rx_crc_ok and out_rx_err hold their values until the next out_rx_done.
- State DROP:
  - Ignores bytes until in_rxen=0.
  - If entered from DATA (oversize): emits out_rx_done with err=1, crc_ok=0, len=MAX_FRAME-4.
  - If entered from IDLE or PREAMBLE: silently returns to IDLE.
- Back-to-back frames: in_rxen may rise again in the same cycle out_rx_done is asserted.
  - That byte is evaluated from IDLE.
  - A minimum 1-cycle in_rxen low gap is required between frames.
- out_rx_valid never asserts outside DATA.
- No output depends combinationally on the inputs.

Test Plan:
- Valid frame: 7×0x55, 0xD5, 60 bytes 0x00..0x3B, correct FCS.
  - Required: 60 valid beats with data 0x00..0x3B and sof on 0x00.
  - First beat appears one cycle after the 5th post-SFD byte is sampled.
  - done one cycle after in_rxen falls; len=60, crc_ok=1, err=0.
- Same frame with FCS byte 0 XOR 0x01.
  - Required: 60 beats; done with crc_ok=0, err=1, len=60.
- Runt: preamble, SFD, 20 data bytes, correct FCS (24 bytes total).
  - Required: 20 beats; done with crc_ok=1, err=1, len=20.
- Bad preamble: 3×0x55 then 0xD5, then 64 bytes.
  - Required: no valid beat and no done.
  - A following correct frame is received normally.
- Oversize: valid preamble/SFD, then 1600 bytes.
  - Required: exactly 1514 valid beats.
  - done after in_rxen falls with err=1, crc_ok=0, len=1514.
- Reset: reset_n pulsed low after the 30th payload beat.
  - Required: outputs 0 immediately; no done.
  - The next full valid frame gives len=60, crc_ok=1.
